// File: rtl/fft_pkg.sv
// Shared FFT definitions: FSM states, coefficient triple layout and default sizes.
package fft_pkg;

    localparam int COEF_W        = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [COEF_W-1:0] c;
        logic [COEF_W-1:0] cps;
        logic [COEF_W-1:0] cms;
    } triple_t;

endpackage

// File: rtl/twiddle_addr_gen.sv
// Strided address sequencer for twiddle_bank: tracks triple number n, the running
// address (addr += stride, natural AW-bit wrap) and the last-triple flag.
module twiddle_addr_gen
    import fft_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          advance,
    input  logic          finish,
    input  logic [AW:0]   i_count,
    input  logic [AW-1:0] i_stride,
    output logic [AW-1:0] fetch_addr,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    logic [AW:0]   n_r;
    logic [AW:0]   count_r;
    logic [AW-1:0] stride_r;
    logic [AW-1:0] addr_r;
    logic          last_r;

    logic [AW:0]   count_eff_s;
    logic [AW:0]   next_n_s;
    logic          next_last_s;
    logic [AW-1:0] fetch_addr_s;

    assign count_eff_s = (i_count == CNT_ZERO) ? CNT_FULL : i_count;
    assign next_n_s    = n_r + CNT_ONE;

    // Address and last flag of the triple being loaded into the output register this cycle.
    always_comb begin
        fetch_addr_s = ADDR_ZERO;
        next_last_s  = 1'b0;
        if (start) begin
            fetch_addr_s = ADDR_ZERO;
            next_last_s  = (count_eff_s == CNT_ONE);
        end else begin
            fetch_addr_s = addr_r + stride_r;
            next_last_s  = (next_n_s == (count_r - CNT_ONE));
        end
    end

    // Sequence state: restart on start, step on each non-final handshake, clear on the final one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r      <= CNT_ZERO;
            count_r  <= CNT_ONE;
            stride_r <= ADDR_ZERO;
            addr_r   <= ADDR_ZERO;
            last_r   <= 1'b0;
        end else if (start) begin
            n_r      <= CNT_ZERO;
            count_r  <= count_eff_s;
            stride_r <= i_stride;
            addr_r   <= ADDR_ZERO;
            last_r   <= next_last_s;
        end else if (advance) begin
            n_r      <= next_n_s;
            addr_r   <= fetch_addr_s;
            last_r   <= next_last_s;
        end else if (finish) begin
            n_r      <= CNT_ZERO;
            addr_r   <= ADDR_ZERO;
            last_r   <= 1'b0;
        end
    end

    assign fetch_addr = fetch_addr_s;
    assign addr       = addr_r;
    assign last       = last_r;

endmodule

// File: rtl/twiddle_bank.sv
// Twiddle coefficient store and strided sequencer feeding the butterfly over valid/ready.
// Optional macro TWIDDLE_DERIVE_EN: i_CpS carries S and C+S / C-S are computed on write.
module twiddle_bank
    import fft_pkg::*;
#(
    parameter  int MSB   = COEF_W,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [MSB-1:0] i_C,
    input  logic [MSB-1:0] i_CpS,
    input  logic [MSB-1:0] i_CmS,
    input  logic           start,
    input  logic [AW:0]    i_count,
    input  logic [AW-1:0]  i_stride,
    input  logic           i_ready,
    output logic           o_valid,
    output logic [MSB-1:0] o_C,
    output logic [MSB-1:0] o_CpS,
    output logic [MSB-1:0] o_CmS,
    output logic [AW-1:0]  o_idx,
    output logic           o_last,
    output logic           busy
);

    localparam logic [MSB-1:0] COEF_ZERO = {MSB{1'b0}};

    logic [MSB-1:0] mem_c_r   [DEPTH];
    logic [MSB-1:0] mem_cps_r [DEPTH];
    logic [MSB-1:0] mem_cms_r [DEPTH];

    state_t         state_r;
    logic [MSB-1:0] wr_cps_s;
    logic [MSB-1:0] wr_cms_s;
    logic [AW-1:0]  fetch_addr_s;
    logic           accept_s;
    logic           launch_s;
    logic           advance_s;
    logic           finish_s;

`ifdef TWIDDLE_DERIVE_EN
    logic unused_cms_s;
    assign wr_cps_s     = i_C + i_CpS;
    assign wr_cms_s     = i_C - i_CpS;
    assign unused_cms_s = ^i_CmS;
`else
    assign wr_cps_s = i_CpS;
    assign wr_cms_s = i_CmS;
`endif

    assign accept_s  = o_valid & i_ready;
    assign launch_s  = (state_r == IDLE) & start;
    assign advance_s = accept_s & ~o_last;
    assign finish_s  = accept_s & o_last;

    twiddle_addr_gen #(
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (launch_s),
        .advance    (advance_s),
        .finish     (finish_s),
        .i_count    (i_count),
        .i_stride   (i_stride),
        .fetch_addr (fetch_addr_s),
        .addr       (o_idx),
        .last       (o_last)
    );

    // Coefficient storage; reads in the same cycle see the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_c_r[i]   <= COEF_ZERO;
                mem_cps_r[i] <= COEF_ZERO;
                mem_cms_r[i] <= COEF_ZERO;
            end
        end else if (we) begin
            mem_c_r[i_waddr]   <= i_C;
            mem_cps_r[i_waddr] <= wr_cps_s;
            mem_cms_r[i_waddr] <= wr_cms_s;
        end
    end

    // Sequencer FSM with registered handshake outputs; next triple loads on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            o_valid <= 1'b0;
            o_C     <= COEF_ZERO;
            o_CpS   <= COEF_ZERO;
            o_CmS   <= COEF_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        o_valid <= 1'b1;
                        o_C     <= mem_c_r[fetch_addr_s];
                        o_CpS   <= mem_cps_r[fetch_addr_s];
                        o_CmS   <= mem_cms_r[fetch_addr_s];
                    end
                end
                RUN: begin
                    if (finish_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        o_valid <= 1'b0;
                        o_C     <= COEF_ZERO;
                        o_CpS   <= COEF_ZERO;
                        o_CmS   <= COEF_ZERO;
                    end else if (advance_s) begin
                        o_C     <= mem_c_r[fetch_addr_s];
                        o_CpS   <= mem_cps_r[fetch_addr_s];
                        o_CmS   <= mem_cms_r[fetch_addr_s];
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
